// File: rtl/imem_port_arb_if.sv
// Bus bundle for imem_port_arb: fetch request/response, data-side access and the shared ITCM port.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface imem_port_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  if_gnt;
    logic                  instr_read_data_valid;
    logic [DATA_WIDTH-1:0] instr_read_data;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [3:0]            d_be;
    logic                  d_gnt;
    logic                  d_rdata_valid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, instr_read_data_valid, instr_read_data,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rdata_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, instr_read_data_valid, instr_read_data,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rdata_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/imem_port_arb.sv
// Shares the single ITCM port between fetch and the data load/store path; data wins by default.
// Define KRV_IMEM_ARB_STARVE_EN to add a guard that lets fetch through after STARVE_LIMIT data wins.
module imem_port_arb #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    imem_port_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_F = 2'd1,
        RESP_D = 2'd2
    } owner_e;

    owner_e                r_owner;
    owner_e                w_ownerNext;
    logic                  w_ifGnt;
    logic                  w_dGnt;
    logic                  w_starveTrip;
    logic [ADDR_WIDTH-1:0] w_memAddr;
    logic [DATA_WIDTH-1:0] w_memWdata;

    if (STARVE_LIMIT < 1) begin : g_limitCheck
        $error("imem_port_arb: STARVE_LIMIT must be at least 1");
    end

`ifdef KRV_IMEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starveCnt;

    // Fetch is only forced through while it is actually asking for the port.
    assign w_starveTrip = bus.if_req && (r_starveCnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_starveCnt <= '0;
        end else if (w_ifGnt || !bus.if_req) begin
            r_starveCnt <= '0;
        end else if (w_dGnt) begin
            r_starveCnt <= r_starveCnt + CNT_W'(1);
        end
    end
`else
    assign w_starveTrip = 1'b0;
`endif

    always_comb begin
        w_dGnt  = bus.mem_ready && bus.d_req && !w_starveTrip;
        w_ifGnt = bus.mem_ready && bus.if_req && !w_dGnt;
    end

    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_be = 4'hF;
        w_memAddr  = bus.if_addr;
        w_memWdata = '0;
        if (w_dGnt) begin
            bus.mem_we = bus.d_we;
            bus.mem_be = bus.d_be;
            w_memAddr  = bus.d_addr;
            w_memWdata = bus.d_wdata;
        end
    end

    assign bus.mem_req   = w_dGnt || w_ifGnt;
    assign bus.mem_addr  = w_memAddr;
    assign bus.mem_wdata = w_memWdata;
    assign bus.if_gnt    = w_ifGnt;
    assign bus.d_gnt     = w_dGnt;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_owner <= IDLE;
        end else begin
            r_owner <= w_ownerNext;
        end
    end

    // A flushed fetch still uses the memory slot but never claims the response.
    always_comb begin
        w_ownerNext               = IDLE;
        bus.instr_read_data_valid = 1'b0;
        bus.instr_read_data       = '0;
        bus.d_rdata_valid         = 1'b0;
        bus.d_rdata               = '0;

        if (w_ifGnt && !bus.if_flush) begin
            w_ownerNext = RESP_F;
        end else if (w_dGnt && !bus.d_we) begin
            w_ownerNext = RESP_D;
        end

        case (r_owner)
            RESP_F: begin
                if (!bus.if_flush) begin
                    bus.instr_read_data_valid = 1'b1;
                    bus.instr_read_data       = bus.mem_rdata;
                end
            end
            RESP_D: begin
                bus.d_rdata_valid = 1'b1;
                bus.d_rdata       = bus.mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_imem_port_arb.sv
// Scoreboard bench for imem_port_arb: a rule-level model queues the expected outputs of each
// cycle and a separate monitor compares them against the DUT on the falling edge.
module tb_imem_port_arb;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

`ifdef KRV_IMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    localparam logic [9:0] STARVE_PATTERN = STARVE_EN ? 10'b10_0001_0000 : 10'b0;

    typedef struct {
        logic          rstn;
        logic          ifReq;
        logic [AW-1:0] ifAddr;
        logic          ifFlush;
        logic          dReq;
        logic          dWe;
        logic [AW-1:0] dAddr;
        logic [DW-1:0] dWdata;
        logic [3:0]    dBe;
        logic          memReady;
        logic [DW-1:0] memRdata;
    } stimT;

    typedef struct {
        logic          ifGnt;
        logic          dGnt;
        logic          memReq;
        logic          memWe;
        logic [AW-1:0] memAddr;
        logic [DW-1:0] memWdata;
        logic [3:0]    memBe;
        logic          iValid;
        logic [DW-1:0] iData;
        logic          dValid;
        logic [DW-1:0] dData;
    } expT;

    logic cpu_clk  = 1'b0;
    logic cpu_rstn = 1'b0;

    imem_port_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_port_arb #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rstn(cpu_rstn),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    expT expQ[$];
    int  nCompared   = 0;
    int  nMismatched = 0;

    // Reference state: who owns the response due next cycle (0 none, 1 fetch, 2 data),
    // and how many data wins in a row fetch has sat through.
    int pendingOwner  = 0;
    int dataWinStreak = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic stimT idleStim();
        stimT s;
        s.rstn     = 1'b1;
        s.ifReq    = 1'b0;
        s.ifAddr   = '0;
        s.ifFlush  = 1'b0;
        s.dReq     = 1'b0;
        s.dWe      = 1'b0;
        s.dAddr    = '0;
        s.dWdata   = '0;
        s.dBe      = 4'h0;
        s.memReady = 1'b1;
        s.memRdata = $urandom;
        return s;
    endfunction

    task automatic applyStimulus(input stimT s);
        expT e;
        bit  fetchMustWin;
        @(posedge cpu_clk);
        #1;
        cpu_rstn      = s.rstn;
        bus.if_req    = s.ifReq;
        bus.if_addr   = s.ifAddr;
        bus.if_flush  = s.ifFlush;
        bus.d_req     = s.dReq;
        bus.d_we      = s.dWe;
        bus.d_addr    = s.dAddr;
        bus.d_wdata   = s.dWdata;
        bus.d_be      = s.dBe;
        bus.mem_ready = s.memReady;
        bus.mem_rdata = s.memRdata;

        if (!s.rstn) begin
            pendingOwner  = 0;
            dataWinStreak = 0;
        end

        fetchMustWin = STARVE_EN && s.ifReq && (dataWinStreak >= LIMIT);
        e.dGnt     = s.memReady && s.dReq && !fetchMustWin;
        e.ifGnt    = s.memReady && s.ifReq && !e.dGnt;
        e.memReq   = e.dGnt || e.ifGnt;
        e.memWe    = e.dGnt ? s.dWe : 1'b0;
        e.memAddr  = e.dGnt ? s.dAddr : s.ifAddr;
        e.memWdata = s.dWdata;
        e.memBe    = e.dGnt ? s.dBe : 4'hF;
        e.iValid   = (pendingOwner == 1) && !s.ifFlush;
        e.iData    = e.iValid ? s.memRdata : '0;
        e.dValid   = (pendingOwner == 2);
        e.dData    = e.dValid ? s.memRdata : '0;

        if (s.rstn) begin
            if (e.ifGnt && !s.ifFlush)   pendingOwner = 1;
            else if (e.dGnt && !s.dWe)   pendingOwner = 2;
            else                         pendingOwner = 0;
            if (e.ifGnt || !s.ifReq)     dataWinStreak = 0;
            else if (e.dGnt)             dataWinStreak++;
        end
        expQ.push_back(e);
    endtask

    always @(negedge cpu_clk) begin
        expT e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("if_gnt",     32'(bus.if_gnt),                e.ifGnt);
            checkOutput("d_gnt",      32'(bus.d_gnt),                 e.dGnt);
            checkOutput("mem_req",    32'(bus.mem_req),               e.memReq);
            checkOutput("i_valid",    32'(bus.instr_read_data_valid), e.iValid);
            checkOutput("i_data",     bus.instr_read_data,            e.iData);
            checkOutput("d_valid",    32'(bus.d_rdata_valid),         e.dValid);
            checkOutput("d_rdata",    bus.d_rdata,                    e.dData);
            if (e.memReq) begin
                checkOutput("mem_addr", bus.mem_addr,        e.memAddr);
                checkOutput("mem_we",   32'(bus.mem_we),     e.memWe);
                checkOutput("mem_be",   32'(bus.mem_be),     32'(e.memBe));
            end
            if (e.dGnt && e.memWe) begin
                checkOutput("mem_wdata", bus.mem_wdata, e.memWdata);
            end
        end
    end

    initial begin
        stimT       s;
        logic [9:0] pattern;

        cpu_rstn      = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_be      = 4'h0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '0;

        // Held in reset: no responses, grants still follow requests.
        s = idleStim(); s.rstn = 1'b0; s.ifReq = 1'b1; s.ifAddr = 32'h40;
        applyStimulus(s);
        s = idleStim(); s.rstn = 1'b0; s.dReq = 1'b1; s.dAddr = 32'h80;
        applyStimulus(s);

        // Fetch only.
        s = idleStim(); s.ifReq = 1'b1; s.ifAddr = 32'h100;
        applyStimulus(s);
        s = idleStim(); s.memRdata = 32'h0000_8067;
        applyStimulus(s);

        // Conflict: data read wins.
        s = idleStim(); s.ifReq = 1'b1; s.ifAddr = 32'h104; s.dReq = 1'b1; s.dAddr = 32'h2000;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        // Data write: no response afterwards.
        s = idleStim(); s.dReq = 1'b1; s.dWe = 1'b1; s.dBe = 4'b0011; s.dWdata = 32'hA5A5; s.dAddr = 32'h3000;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        // Starvation: both held after a cycle without fetch demand.
        s = idleStim();
        applyStimulus(s);
        pattern = '0;
        for (int i = 0; i < 10; i++) begin
            s = idleStim(); s.ifReq = 1'b1; s.ifAddr = 32'h200; s.dReq = 1'b1; s.dAddr = 32'h2400;
            applyStimulus(s);
            @(negedge cpu_clk);
            #1;
            pattern[i] = bus.if_gnt;
        end
        checkOutput("starve_pattern", 32'(pattern), 32'(STARVE_PATTERN));

        // Flush in the response cycle, then flush in the grant cycle.
        s = idleStim(); s.ifReq = 1'b1; s.ifAddr = 32'h300;
        applyStimulus(s);
        s = idleStim(); s.ifFlush = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.ifReq = 1'b1; s.ifAddr = 32'h304; s.ifFlush = 1'b1;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        // Stall, and a stall that lands on a response cycle.
        s = idleStim(); s.ifReq = 1'b1; s.dReq = 1'b1; s.memReady = 1'b0;
        applyStimulus(s);
        s = idleStim(); s.dReq = 1'b1; s.dAddr = 32'h2800;
        applyStimulus(s);
        s = idleStim(); s.memReady = 1'b0; s.ifReq = 1'b1;
        applyStimulus(s);

        // Reset asserted in a data response cycle.
        s = idleStim(); s.dReq = 1'b1; s.dAddr = 32'h2C00;
        applyStimulus(s);
        s = idleStim(); s.rstn = 1'b0;
        applyStimulus(s);
        s = idleStim(); s.rstn = 1'b0; s.dReq = 1'b1;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        for (int i = 0; i < 400; i++) begin
            s.rstn     = ($urandom_range(0, 59) != 0);
            s.ifReq    = ($urandom_range(0, 3) != 0);
            s.ifAddr   = $urandom;
            s.ifFlush  = ($urandom_range(0, 7) == 0);
            s.dReq     = ($urandom_range(0, 1) == 1);
            s.dWe      = ($urandom_range(0, 2) == 0);
            s.dAddr    = $urandom;
            s.dWdata   = $urandom;
            s.dBe      = 4'($urandom_range(0, 15));
            s.memReady = ($urandom_range(0, 4) != 0);
            s.memRdata = $urandom;
            applyStimulus(s);
        end

        for (int k = 0; k < 20 && expQ.size() > 0; k++) begin
            @(negedge cpu_clk);
            #1;
        end
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/imem_port_arb.md
# imem_port_arb

Arbiter that shares the single instruction-memory (ITCM) port between the fetch stage and the data-side load/store path. Each cycle at most one requester is granted, and the access is forwarded to the memory. The returned read word is steered back to the requester that owned the access. The block sits between the fetch stage's `pc` output and the ITCM, and supplies `instr_read_data_valid` / `instr_read_data` to fetch.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data/instruction width
- `STARVE_LIMIT`, 4, consecutive data wins allowed while fetch waits (starvation guard only)
- `cpu_clk` in 1: the block's single clock; all state updates on its rising edge
- `cpu_rstn` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch requests a read at `if_addr`
- `if_addr` in ADDR_WIDTH: fetch address (the fetch `pc`)
- `if_flush` in 1: discard any fetch response due next cycle
- `if_gnt` out 1: fetch access accepted this cycle
- `instr_read_data_valid` out 1: instruction returned to fetch
- `instr_read_data` out DATA_WIDTH: returned instruction
- `d_req` in 1: data-side access request
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in ADDR_WIDTH: data address
- `d_wdata` in DATA_WIDTH: write data
- `d_be` in 4: byte enables
- `d_gnt` out 1: data access accepted this cycle
- `d_rdata_valid` out 1: read data returned to the data side
- `d_rdata` out DATA_WIDTH: returned read data
- `mem_req` out 1: access to the memory
- `mem_we` out 1: memory write enable
- `mem_addr` out ADDR_WIDTH: memory address
- `mem_wdata` out DATA_WIDTH: memory write data
- `mem_be` out 4: memory byte enables
- `mem_ready` in 1: memory can accept an access this cycle
- `mem_rdata` in DATA_WIDTH: read data, valid exactly one cycle after an accepted read

## Operation
- Arbitration is combinational. Priority order:
  - If `mem_ready`=0, there are no grants and `mem_req`=0.
  - Else if `d_req`=1 and the starvation guard has not tripped, `d_gnt`=1.
  - Else if `if_req`=1, `if_gnt`=1.
- Memory mux:
  - `mem_req` = `d_gnt` | `if_gnt`.
  - `mem_*` take the granted requester's fields.
  - A fetch access drives `mem_we`=0 and `mem_be`=4'hF.
- Response state machine, register `owner_r`:
  - States: IDLE, RESP_F, RESP_D.
  - On every edge the next state is set as follows:
    - `if_gnt` & !`if_flush` → RESP_F
    - `d_gnt` & !`d_we` → RESP_D
    - otherwise → IDLE
  - Back-to-back accesses are allowed: a new grant can occur in any state.
- Response outputs:
  - In RESP_F: `instr_read_data_valid`=1 and `instr_read_data`=`mem_rdata`, unless `if_flush`=1 in that cycle, in which case valid is 0.
  - In RESP_D: `d_rdata_valid`=1 and `d_rdata`=`mem_rdata`.
  - In all other cases both valids are 0 and both data outputs are 0.
- Writes produce no response; `d_gnt` is the write completion.
- A fetch request that loses arbitration simply sees `if_gnt`=0 and no valid. Fetch holds `pc` because its `instr_read_data_valid` is low.
- Simultaneous events:
  - `if_flush` in the grant cycle: the fetch access still goes to memory, but its response is dropped.
  - `if_flush` in the response cycle: valid is suppressed.

## Timing
- Grant to response latency is 1 cycle.
- Sustained throughput is 1 access per cycle.
- Reset (`cpu_rstn`=0, asynchronous):
  - `owner_r` goes to IDLE; the starvation counter goes to 0.
  - Both valids read 0; both rdata outputs read 0.
  - Grants and `mem_req` follow requests combinationally.
- A response due when reset asserts is lost; no response appears after reset releases.
- `mem_ready`=0 while in a RESP state does not delay that response.

## Configuration
- `KRV_IMEM_ARB_STARVE_EN` defined: a starvation counter is present.
  - Width is clog2(`STARVE_LIMIT`+1).
  - It increments on each `d_gnt` cycle with `if_req`=1.
  - It clears on `if_gnt` or when `if_req`=0.
  - When it equals `STARVE_LIMIT`, the guard trips: fetch wins the next eligible cycle even if `d_req`=1, and the counter clears.
- `KRV_IMEM_ARB_STARVE_EN` undefined: strict data-over-fetch priority. No counter exists and `STARVE_LIMIT` is unused.

## Test plan
- Fetch only, no conflict:
  - Stimulus: `if_req`=1, `if_addr`=0x100, `mem_ready`=1.
  - Response: `if_gnt`=1 and `mem_addr`=0x100. Next cycle `instr_read_data_valid`=1 and `instr_read_data`=`mem_rdata`=0x00008067.
- Conflict:
  - Stimulus: `if_req`=1 and `d_req`=1 (read, 0x2000).
  - Response: `d_gnt`=1, `if_gnt`=0. Next cycle `d_rdata_valid`=1 and `instr_read_data_valid`=0.
- Data write:
  - Stimulus: `d_we`=1, `d_be`=4'b0011, `d_wdata`=0xA5A5.
  - Response: `mem_we`=1, `mem_be`=4'b0011, and no valid on the next cycle.
- Starvation, with the macro defined and `STARVE_LIMIT`=4:
  - Stimulus: `d_req` and `if_req` both held at 1.
  - Response: 4 data grants, then 1 `if_gnt`, repeating.
  - With the macro undefined: `if_gnt` never asserts.
- Flush in the response cycle:
  - Stimulus: `if_flush`=1 in the cycle after `if_gnt`.
  - Response: `instr_read_data_valid`=0.
- Stall and reset:
  - Stimulus: `mem_ready`=0.
  - Response: no grants and `mem_req`=0.
  - Stimulus: assert `cpu_rstn`=0 in a RESP_D cycle.
  - Response: `d_rdata_valid` drops immediately and stays 0 after release.
